// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerator command sequencer.
package accel_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CHECK    = 4'd1,
    S_LD_WGT   = 4'd2,
    S_WAIT_WGT = 4'd3,
    S_LD_IN    = 4'd4,
    S_WAIT_IN  = 4'd5,
    S_CMP      = 4'd6,
    S_WAIT_CMP = 4'd7,
    S_ST_OUT   = 4'd8,
    S_WAIT_OUT = 4'd9,
    S_DONE     = 4'd10,
    S_ERR      = 4'd11
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_WDOG  = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_BUSY      = 0;
  localparam int ST_DONE      = 1;
  localparam int ST_ERR       = 2;
  localparam int ST_ABORT     = 3;
  localparam int ST_STATE_LSB = 4;
  localparam int ST_ERR_LSB   = 8;
  localparam int ST_REM_LSB   = 16;

  function automatic logic is_wait(input state_e s);
    return (s == S_WAIT_WGT) || (s == S_WAIT_IN) || (s == S_WAIT_CMP) || (s == S_WAIT_OUT);
  endfunction

  // States where the sequencer is parked and accepts a new start
  function automatic logic is_parked(input state_e s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
  endfunction

endpackage

// File: rtl/dma_chunker.sv
// Splits one DMA phase into requests of at most MAX_CHUNK bytes,
// one request outstanding at a time.
module dma_chunker #(
  parameter int DATA_W    = 32,
  parameter int MAX_CHUNK = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] base_i,
  input  logic [DATA_W-1:0] size_i,
  input  logic              valid_d_i,
  input  logic              req_ready_i,
  input  logic              done_i,
  output logic              req_valid_o,
  output logic [DATA_W-1:0] req_addr_o,
  output logic [DATA_W-1:0] req_len_o,
  output logic              fire_o,
  output logic              last_o,
  output logic [DATA_W-1:0] rem_o
);

  localparam logic [DATA_W-1:0] MAX_LEN = DATA_W'(MAX_CHUNK);

  logic [DATA_W-1:0] cursor_q, cursor_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] chunk_q, chunk_d;
  logic              valid_q;

  // Reload at phase start, advance one chunk per completed request
  always_comb begin
    cursor_d = cursor_q;
    rem_d    = rem_q;
    if (load_i) begin
      cursor_d = base_i;
      rem_d    = size_i;
    end else if (done_i) begin
      cursor_d = cursor_q + chunk_q;
      rem_d    = rem_q - chunk_q;
    end
    chunk_d = (rem_d > MAX_LEN) ? MAX_LEN : rem_d;
  end

  // Cursor, remaining, chunk length and request valid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cursor_q <= '0;
      rem_q    <= '0;
      chunk_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      cursor_q <= cursor_d;
      rem_q    <= rem_d;
      chunk_q  <= chunk_d;
      valid_q  <= valid_d_i;
    end
  end

  assign req_valid_o = valid_q;
  assign req_addr_o  = cursor_q;
  assign req_len_o   = chunk_q;
  assign fire_o      = valid_q && req_ready_i;
  assign last_o      = (rem_q == chunk_q);
  assign rem_o       = rem_q;

endmodule

// File: rtl/accel_cmd_sequencer.sv
// Sequences one accelerator job: weight load, input load, compute, output store.
module accel_cmd_sequencer
  import accel_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MAX_CHUNK   = 4096,
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   control_reg,
  input  logic [DATA_W-1:0]   wgt_base_addr_reg,
  input  logic [DATA_W-1:0]   wgt_size_reg,
  input  logic [DATA_W-1:0]   input_base_addr_reg,
  input  logic [DATA_W-1:0]   input_size_reg,
  input  logic [DATA_W-1:0]   output_base_addr_reg,
  input  logic [DATA_W-1:0]   output_size_reg,
  input  logic [DATA_W-1:0]   op_code_reg,
  input  logic [DATA_W-1:0]   op_params_reg_0,
  input  logic [DATA_W-1:0]   op_params_reg_1,
  output logic                rd_req_valid,
  input  logic                rd_req_ready,
  output logic [DATA_W-1:0]   rd_req_addr,
  output logic [DATA_W-1:0]   rd_req_len,
  output logic                rd_req_dst,
  input  logic                rd_done,
  output logic                cmp_start,
  output logic [DATA_W-1:0]   cmp_op_code,
  output logic [2*DATA_W-1:0] cmp_params,
  input  logic                cmp_done,
  output logic                wr_req_valid,
  input  logic                wr_req_ready,
  output logic [DATA_W-1:0]   wr_req_addr,
  output logic [DATA_W-1:0]   wr_req_len,
  input  logic                wr_done,
  output logic [31:0]         status_reg_rdata,
  output logic                irq
);

  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              start_q, start_edge, latch;
  logic              done_q, done_d, err_q, err_d;
  logic              abort_pend_q, abort_pend_d;
  logic              irq_en_q, irq_en_d, irq_q, irq_d;
  logic [31:0]       wdog_q, wdog_d;
  logic              wdog_hit;
  logic              cmp_start_q, rd_dst_q;
  logic [31:0]       status_q, status_d;

  logic [DATA_W-1:0] wgt_base_q, wgt_size_q, in_base_q, in_size_q, out_base_q, out_size_q;
  logic [DATA_W-1:0] op_q, p0_q, p1_q;
  logic              misaligned;

  logic              rd_load, rd_sel_in, wr_load;
  logic              rd_fire, rd_last, wr_fire, wr_last;
  logic              rd_done_g, wr_done_g;
  logic [DATA_W-1:0] rd_rem, wr_rem, rem_sel;
  logic              unused_bits;

  assign start_edge = control_reg[CTRL_START] && !start_q;
  assign misaligned = |{wgt_base_q[1:0], wgt_size_q[1:0], in_base_q[1:0],
                        in_size_q[1:0], out_base_q[1:0], out_size_q[1:0]};
  assign rd_done_g  = rd_done && ((state_q == S_WAIT_WGT) || (state_q == S_WAIT_IN));
  assign wr_done_g  = wr_done && (state_q == S_WAIT_OUT);
  assign wdog_hit   = (wdog_q == WDOG_LAST);

  dma_chunker #(.DATA_W(DATA_W), .MAX_CHUNK(MAX_CHUNK)) u_rd (
    .clk(clk), .rst(rst), .load_i(rd_load),
    .base_i(rd_sel_in ? in_base_q : wgt_base_q),
    .size_i(rd_sel_in ? in_size_q : wgt_size_q),
    .valid_d_i((state_d == S_LD_WGT) || (state_d == S_LD_IN)),
    .req_ready_i(rd_req_ready), .done_i(rd_done_g),
    .req_valid_o(rd_req_valid), .req_addr_o(rd_req_addr), .req_len_o(rd_req_len),
    .fire_o(rd_fire), .last_o(rd_last), .rem_o(rd_rem)
  );

  dma_chunker #(.DATA_W(DATA_W), .MAX_CHUNK(MAX_CHUNK)) u_wr (
    .clk(clk), .rst(rst), .load_i(wr_load),
    .base_i(out_base_q), .size_i(out_size_q),
    .valid_d_i(state_d == S_ST_OUT),
    .req_ready_i(wr_req_ready), .done_i(wr_done_g),
    .req_valid_o(wr_req_valid), .req_addr_o(wr_req_addr), .req_len_o(wr_req_len),
    .fire_o(wr_fire), .last_o(wr_last), .rem_o(wr_rem)
  );

  // Next-state logic: phase sequencing, error and abort handling
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    latch      = 1'b0;
    rd_load    = 1'b0;
    rd_sel_in  = 1'b0;
    wr_load    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_edge) begin
          latch      = 1'b1;
          err_code_d = ERR_NONE;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (misaligned) begin
          state_d    = S_ERR;
          err_code_d = ERR_ALIGN;
        end else if (wgt_size_q != '0) begin
          state_d = S_LD_WGT;
          rd_load = 1'b1;
        end else if (in_size_q != '0) begin
          state_d   = S_LD_IN;
          rd_load   = 1'b1;
          rd_sel_in = 1'b1;
        end else begin
          state_d = S_CMP;
        end
      end
      S_LD_WGT, S_LD_IN: begin
        // A request already accepted must be seen through; abort waits for its done
        if (rd_fire) begin
          state_d = (state_q == S_LD_WGT) ? S_WAIT_WGT : S_WAIT_IN;
        end else if (abort_pend_q) begin
          state_d    = S_ERR;
          err_code_d = ERR_ABORT;
        end
      end
      S_WAIT_WGT, S_WAIT_IN: begin
        if (rd_done_g) begin
          if (abort_pend_q) begin
            state_d    = S_ERR;
            err_code_d = ERR_ABORT;
          end else if (!rd_last) begin
            state_d = (state_q == S_WAIT_WGT) ? S_LD_WGT : S_LD_IN;
          end else if ((state_q == S_WAIT_WGT) && (in_size_q != '0)) begin
            state_d   = S_LD_IN;
            rd_load   = 1'b1;
            rd_sel_in = 1'b1;
          end else begin
            state_d = S_CMP;
          end
        end else if (wdog_hit) begin
          state_d    = S_ERR;
          err_code_d = abort_pend_q ? ERR_ABORT : ERR_WDOG;
        end
      end
      S_CMP: state_d = S_WAIT_CMP;
      S_WAIT_CMP: begin
        if (cmp_done) begin
          if (abort_pend_q) begin
            state_d    = S_ERR;
            err_code_d = ERR_ABORT;
          end else if (out_size_q != '0) begin
            state_d = S_ST_OUT;
            wr_load = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else if (wdog_hit) begin
          state_d    = S_ERR;
          err_code_d = abort_pend_q ? ERR_ABORT : ERR_WDOG;
        end
      end
      S_ST_OUT: begin
        if (wr_fire) begin
          state_d = S_WAIT_OUT;
        end else if (abort_pend_q) begin
          state_d    = S_ERR;
          err_code_d = ERR_ABORT;
        end
      end
      S_WAIT_OUT: begin
        if (wr_done_g) begin
          if (abort_pend_q) begin
            state_d    = S_ERR;
            err_code_d = ERR_ABORT;
          end else if (!wr_last) begin
            state_d = S_ST_OUT;
          end else begin
            state_d = S_DONE;
          end
        end else if (wdog_hit) begin
          state_d    = S_ERR;
          err_code_d = abort_pend_q ? ERR_ABORT : ERR_WDOG;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky flags, abort request, watchdog and status word
  always_comb begin
    done_d       = latch ? 1'b0 : ((state_d == S_DONE) || done_q);
    err_d        = latch ? 1'b0 : ((state_d == S_ERR) || err_q);
    abort_pend_d = is_parked(state_q) ? 1'b0 : (control_reg[CTRL_ABORT] || abort_pend_q);
    irq_en_d     = latch ? control_reg[CTRL_IRQ_EN] : irq_en_q;
    irq_d        = irq_en_d && (done_d || err_d);
    wdog_d       = (state_d != state_q) ? '0 : (is_wait(state_q) ? wdog_q + 32'd1 : wdog_q);
    case (state_q)
      S_LD_WGT, S_WAIT_WGT, S_LD_IN, S_WAIT_IN: rem_sel = rd_rem;
      S_ST_OUT, S_WAIT_OUT:                     rem_sel = wr_rem;
      default:                                  rem_sel = '0;
    endcase
    status_d                             = '0;
    status_d[ST_BUSY]                    = !is_parked(state_q);
    status_d[ST_DONE]                    = done_q;
    status_d[ST_ERR]                     = err_q;
    status_d[ST_ABORT]                   = abort_pend_q;
    status_d[ST_STATE_LSB +: 4]          = state_q;
    status_d[ST_ERR_LSB +: 2]            = err_code_q;
    status_d[ST_REM_LSB +: 16]           = rem_sel[17:2];
  end

  // Control-path registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      err_code_q   <= ERR_NONE;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      abort_pend_q <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
      wdog_q       <= '0;
      cmp_start_q  <= 1'b0;
      rd_dst_q     <= 1'b0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      err_code_q   <= err_code_d;
      start_q      <= control_reg[CTRL_START];
      done_q       <= done_d;
      err_q        <= err_d;
      abort_pend_q <= abort_pend_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
      wdog_q       <= wdog_d;
      cmp_start_q  <= (state_d == S_CMP);
      if (rd_load) rd_dst_q <= rd_sel_in;
      status_q     <= status_d;
    end
  end

  // Job registers, captured on an accepted start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      wgt_base_q <= '0; wgt_size_q <= '0;
      in_base_q  <= '0; in_size_q  <= '0;
      out_base_q <= '0; out_size_q <= '0;
      op_q       <= '0; p0_q       <= '0; p1_q <= '0;
    end else if (latch) begin
      wgt_base_q <= wgt_base_addr_reg;    wgt_size_q <= wgt_size_reg;
      in_base_q  <= input_base_addr_reg;  in_size_q  <= input_size_reg;
      out_base_q <= output_base_addr_reg; out_size_q <= output_size_reg;
      op_q       <= op_code_reg;          p0_q       <= op_params_reg_0;
      p1_q       <= op_params_reg_1;
    end
  end

  assign rd_req_dst       = rd_dst_q;
  assign cmp_start        = cmp_start_q;
  assign cmp_op_code      = op_q;
  assign cmp_params       = {p1_q, p0_q};
  assign status_reg_rdata = status_q;
  assign irq              = irq_q;

  assign unused_bits = &{1'b0, control_reg[DATA_W-1:3], rem_sel[DATA_W-1:18], rem_sel[1:0]};

endmodule

// File: tb/tb_accel_cmd_sequencer.sv
// Directed bench for accel_cmd_sequencer with auto-responding DMA/compute models.
module tb_accel_cmd_sequencer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    logic        dst;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] control_reg = '0;
  logic [31:0] wgt_base = '0, wgt_size = '0, in_base = '0, in_size = '0;
  logic [31:0] out_base = '0, out_size = '0, op_code = '0, p0 = '0, p1 = '0;
  logic        rd_req_valid, rd_req_dst, cmp_start, wr_req_valid, irq;
  logic        rd_req_ready = 1'b1, wr_req_ready = 1'b1;
  logic        rd_done = 1'b0, cmp_done = 1'b0, wr_done = 1'b0;
  logic [31:0] rd_req_addr, rd_req_len, cmp_op_code, wr_req_addr, wr_req_len, status;
  logic [63:0] cmp_params;

  int checks = 0;
  int errors = 0;

  int   rd_cnt = 0, wr_cnt = 0, c_cnt = 0, rd_delay = 3;
  bit   rd_auto = 1'b1;
  req_t rd_log[$];
  req_t wr_log[$];
  int   cmp_seen = 0;
  logic [31:0] cmp_op_seen = '0;
  logic [63:0] cmp_par_seen = '0;

  accel_cmd_sequencer #(.DATA_W(32), .MAX_CHUNK(4096), .WDOG_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .control_reg(control_reg),
    .wgt_base_addr_reg(wgt_base), .wgt_size_reg(wgt_size),
    .input_base_addr_reg(in_base), .input_size_reg(in_size),
    .output_base_addr_reg(out_base), .output_size_reg(out_size),
    .op_code_reg(op_code), .op_params_reg_0(p0), .op_params_reg_1(p1),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_req_len(rd_req_len), .rd_req_dst(rd_req_dst), .rd_done(rd_done),
    .cmp_start(cmp_start), .cmp_op_code(cmp_op_code), .cmp_params(cmp_params), .cmp_done(cmp_done),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_len(wr_req_len), .wr_done(wr_done),
    .status_reg_rdata(status), .irq(irq)
  );

  // Responders: log each handshake, answer with a done pulse a few cycles later
  always @(negedge clk) begin : responder
    req_t r;
    rd_done  = 1'b0;
    wr_done  = 1'b0;
    cmp_done = 1'b0;
    if (rd_cnt > 0) begin rd_cnt--; if (rd_cnt == 0) rd_done = rd_auto; end
    if (wr_cnt > 0) begin wr_cnt--; if (wr_cnt == 0) wr_done = 1'b1; end
    if (c_cnt > 0)  begin c_cnt--;  if (c_cnt == 0)  cmp_done = 1'b1; end
    if (!rst && rd_req_valid && rd_req_ready) begin
      r.addr = rd_req_addr; r.len = rd_req_len; r.dst = rd_req_dst;
      rd_log.push_back(r);
      rd_cnt = rd_delay;
    end
    if (!rst && wr_req_valid && wr_req_ready) begin
      r.addr = wr_req_addr; r.len = wr_req_len; r.dst = 1'b0;
      wr_log.push_back(r);
      wr_cnt = 3;
    end
    if (!rst && cmp_start) begin
      cmp_seen++;
      cmp_op_seen  = cmp_op_code;
      cmp_par_seen = cmp_params;
      c_cnt = 3;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_regs(input logic [31:0] wb, ws, ib, is, ob, os);
    wgt_base = wb; wgt_size = ws; in_base = ib; in_size = is; out_base = ob; out_size = os;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_log.delete();
    cmp_seen = 0;
  endtask

  // Raise start for one cycle; returns just after the edge that samples it
  task automatic start_job(input logic irq_en);
    control_reg = 32'h1 | (irq_en ? 32'h4 : 32'h0);
    tick();
    control_reg[0] = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      ok = (status[7:4] == s);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (status !== 32'h0) begin errors++; $display("FAIL reset_status got %h want %h", status, 32'h0); end
    checks++;
    if ({rd_req_valid, wr_req_valid, cmp_start, irq, rd_req_dst} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {rd_req_valid, wr_req_valid, cmp_start, irq, rd_req_dst});
    end
    checks++;
    if ({rd_req_addr, rd_req_len, wr_req_addr, cmp_op_code} !== 128'h0) begin
      errors++; $display("FAIL reset_data got %h want 0", {rd_req_addr, rd_req_len, wr_req_addr, cmp_op_code});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic(input logic irq_en);
    bit ok;
    clear_logs();
    set_regs(32'h1000, 256, 32'h2000, 128, 32'h3000, 64);
    op_code = 32'd5; p0 = 32'h11; p1 = 32'h22;
    start_job(irq_en);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_clear got %b want 0", irq); end
    wait_state(4'd10, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout status %h want DONE", status); end
    checks++;
    if (rd_log.size() != 2) begin
      errors++; $display("FAIL basic_rd_count got %0d want 2", rd_log.size());
    end else begin
      checks++;
      if (rd_log[0].addr !== 32'h1000 || rd_log[0].len !== 32'd256 || rd_log[0].dst !== 1'b0) begin
        errors++; $display("FAIL basic_rd0 got %h/%0d/%b want 1000/256/0", rd_log[0].addr, rd_log[0].len, rd_log[0].dst);
      end
      checks++;
      if (rd_log[1].addr !== 32'h2000 || rd_log[1].len !== 32'd128 || rd_log[1].dst !== 1'b1) begin
        errors++; $display("FAIL basic_rd1 got %h/%0d/%b want 2000/128/1", rd_log[1].addr, rd_log[1].len, rd_log[1].dst);
      end
    end
    checks++;
    if (cmp_seen != 1 || cmp_op_seen !== 32'd5 || cmp_par_seen !== 64'h00000022_00000011) begin
      errors++; $display("FAIL basic_cmp got n=%0d op=%h par=%h want 1/5/2200000011", cmp_seen, cmp_op_seen, cmp_par_seen);
    end
    checks++;
    if (wr_log.size() != 1) begin
      errors++; $display("FAIL basic_wr_count got %0d want 1", wr_log.size());
    end else begin
      checks++;
      if (wr_log[0].addr !== 32'h3000 || wr_log[0].len !== 32'd64) begin
        errors++; $display("FAIL basic_wr0 got %h/%0d want 3000/64", wr_log[0].addr, wr_log[0].len);
      end
    end
    checks++;
    if (status !== 32'h000000A2) begin errors++; $display("FAIL basic_status got %h want 000000a2", status); end
    checks++;
    if (irq !== irq_en) begin errors++; $display("FAIL basic_irq got %b want %b", irq, irq_en); end
  endtask

  task automatic test_chunking();
    bit ok;
    clear_logs();
    set_regs(32'h10000, 10000, 32'h0, 0, 32'h0, 0);
    start_job(1'b0);
    repeat (3) tick();
    checks++;
    if (status !== 32'h09C40031) begin errors++; $display("FAIL chunk_rem_status got %h want 09c40031", status); end
    wait_state(4'd10, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL chunk_timeout status %h want DONE", status); end
    checks++;
    if (rd_log.size() != 3) begin
      errors++; $display("FAIL chunk_count got %0d want 3", rd_log.size());
    end else begin
      checks++;
      if (rd_log[0].addr !== 32'h10000 || rd_log[0].len !== 32'd4096) begin
        errors++; $display("FAIL chunk0 got %h/%0d want 10000/4096", rd_log[0].addr, rd_log[0].len);
      end
      checks++;
      if (rd_log[1].addr !== 32'h11000 || rd_log[1].len !== 32'd4096) begin
        errors++; $display("FAIL chunk1 got %h/%0d want 11000/4096", rd_log[1].addr, rd_log[1].len);
      end
      checks++;
      if (rd_log[2].addr !== 32'h12000 || rd_log[2].len !== 32'd1808) begin
        errors++; $display("FAIL chunk2 got %h/%0d want 12000/1808", rd_log[2].addr, rd_log[2].len);
      end
    end
  endtask

  task automatic test_zero_sizes();
    bit ok;
    clear_logs();
    set_regs(32'h1000, 0, 32'h2000, 0, 32'h3000, 0);
    op_code = 32'd9;
    start_job(1'b0);
    wait_state(4'd10, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_timeout status %h want DONE", status); end
    checks++;
    if (rd_log.size() != 0 || wr_log.size() != 0) begin
      errors++; $display("FAIL zero_reqs got rd=%0d wr=%0d want 0/0", rd_log.size(), wr_log.size());
    end
    checks++;
    if (cmp_seen != 1 || cmp_op_seen !== 32'd9) begin
      errors++; $display("FAIL zero_cmp got n=%0d op=%h want 1/9", cmp_seen, cmp_op_seen);
    end
    checks++;
    if (status !== 32'h000000A2) begin errors++; $display("FAIL zero_status got %h want 000000a2", status); end
  endtask

  task automatic test_misaligned();
    clear_logs();
    set_regs(32'h1000, 256, 32'h2002, 128, 32'h3000, 64);
    start_job(1'b1);
    tick();
    checks++;
    if (status[7:4] !== 4'd1) begin errors++; $display("FAIL align_check_state got %0d want 1", status[7:4]); end
    tick();
    checks++;
    if (status !== 32'h000001B4) begin errors++; $display("FAIL align_status got %h want 000001b4", status); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL align_irq got %b want 1", irq); end
    repeat (5) tick();
    checks++;
    if (rd_log.size() != 0 || wr_log.size() != 0 || cmp_seen != 0) begin
      errors++; $display("FAIL align_reqs got rd=%0d wr=%0d cmp=%0d want 0/0/0", rd_log.size(), wr_log.size(), cmp_seen);
    end
  endtask

  task automatic test_watchdog();
    clear_logs();
    rd_auto = 1'b0;
    set_regs(32'h1000, 256, 32'h2000, 0, 32'h3000, 0);
    start_job(1'b0);
    repeat (52) tick();
    checks++;
    if (status !== 32'h00400031) begin errors++; $display("FAIL wdog_before got %h want 00400031", status); end
    tick();
    checks++;
    if (status !== 32'h000002B4) begin errors++; $display("FAIL wdog_err got %h want 000002b4", status); end
    rd_auto = 1'b1;
  endtask

  task automatic test_abort_restart();
    bit ok;
    clear_logs();
    rd_delay = 8;
    set_regs(32'h1000, 64, 32'h2000, 64, 32'h3000, 16);
    start_job(1'b0);
    wait_state(4'd5, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_reach_wait_in status %h", status); end
    control_reg[1] = 1'b1;
    repeat (2) tick();
    checks++;
    if (status !== 32'h00100059) begin errors++; $display("FAIL abort_pending got %h want 00100059", status); end
    control_reg[1] = 1'b0;
    repeat (2) tick();
    checks++;
    if (status[7:4] !== 4'd5 || status[3] !== 1'b1) begin
      errors++; $display("FAIL abort_hold got state=%0d pend=%b want 5/1", status[7:4], status[3]);
    end
    wait_state(4'd11, 20, ok);
    checks++;
    if (!ok || status[9:8] !== 2'd3 || status[2:1] !== 2'b10) begin
      errors++; $display("FAIL abort_err got %h want state b code 3 err 1", status);
    end
    tick();
    checks++;
    if (status !== 32'h000003B4) begin errors++; $display("FAIL abort_cleared got %h want 000003b4", status); end
    checks++;
    if (rd_log.size() != 2 || wr_log.size() != 0 || cmp_seen != 0) begin
      errors++; $display("FAIL abort_reqs got rd=%0d wr=%0d cmp=%0d want 2/0/0", rd_log.size(), wr_log.size(), cmp_seen);
    end
    rd_delay = 3;
    clear_logs();
    start_job(1'b0);
    repeat (3) tick();
    control_reg[0] = 1'b1;
    tick();
    control_reg[0] = 1'b0;
    wait_state(4'd10, 200, ok);
    checks++;
    if (!ok || status !== 32'h000000A2) begin errors++; $display("FAIL restart_status got %h want 000000a2", status); end
    checks++;
    if (rd_log.size() != 2 || wr_log.size() != 1 || cmp_seen != 1) begin
      errors++; $display("FAIL restart_reqs got rd=%0d wr=%0d cmp=%0d want 2/1/1", rd_log.size(), wr_log.size(), cmp_seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic(1'b1);
    test_basic(1'b0);
    test_chunking();
    test_zero_sizes();
    test_misaligned();
    test_watchdog();
    test_abort_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
